// File: rtl/btn_reset_conditioner.sv
// btn_reset_conditioner
// Conditions the raw reset and NMI board buttons for the system core.
// Each button is synchronised (two flops), normalised to pressed=1 and
// debounced. The debounced reset button, together with power-on (RST),
// drives a small FSM that stretches SYS_RESET to at least RESET_HOLD
// cycles. A debounced NMI press seen while running becomes a one-cycle
// NMI_PULSE.
//
// The FSM and the NMI edge detector look at the debounced value being
// committed on the current edge (btn_next). SYS_RESET and NMI_PULSE
// therefore change on the same edge as the BTN_STATE bit that causes
// them. Every output is a flop, so no input reaches an output
// combinationally.
//
// Handshake: this block has no valid/ready interfaces. All outputs are
// plain registered levels, except NMI_PULSE, which is a one-cycle strobe
// with no back-pressure.

module btn_reset_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 320000,
  parameter int unsigned RESET_HOLD      = 1024,
  parameter bit          BTN_ACTIVE      = 1'b1
) (
  input  logic       CLK_32MHZ,
  input  logic       RST,
  input  logic       BTN_RESET_RAW,
  input  logic       BTN_NMI_RAW,
  output logic       SYS_RESET,
  output logic       NMI_PULSE,
  output logic [1:0] BTN_STATE
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(RESET_HOLD);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    RUN      = 2'd1,
    BTN_HELD = 2'd2,
    REL_HOLD = 2'd3
  } state_t;

  // Bit 1 carries the NMI button and bit 0 the reset button, in every vector below.
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         pressed;
  logic [1:0][DW-1:0] db_cnt;
  logic [1:0][DW-1:0] cnt_next;
  logic [1:0]         btn_next;

  state_t             state;
  state_t             state_next;
  logic [HW-1:0]      hold_cnt;
  logic [HW-1:0]      hold_next;
  logic               nmi_next;

  // Two-flop synchronisers. On reset they hold the raw not-pressed level.
  always_ff @(posedge CLK_32MHZ) begin
    if (RST) begin
      sync1 <= {2{~BTN_ACTIVE}};
      sync2 <= {2{~BTN_ACTIVE}};
    end else begin
      sync1 <= {BTN_NMI_RAW, BTN_RESET_RAW};
      sync2 <= sync1;
    end
  end

  // Convert the synchronised raw level to pressed=1, whatever the button polarity.
  assign pressed = BTN_ACTIVE ? sync2 : ~sync2;

  // Debounce step for each button. The count restarts whenever the input agrees with the accepted state.
  always_comb begin
    btn_next = BTN_STATE;
    cnt_next = '0;
    for (int i = 0; i < 2; i++) begin
      if (pressed[i] != BTN_STATE[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          btn_next[i] = pressed[i];
        end else begin
          cnt_next[i] = db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Debounce counters and the accepted button state.
  always_ff @(posedge CLK_32MHZ) begin
    if (RST) begin
      db_cnt    <= '0;
      BTN_STATE <= 2'b00;
    end else begin
      db_cnt    <= cnt_next;
      BTN_STATE <= btn_next;
    end
  end

  // Reset-stretch FSM: next state, hold count and NMI edge detect.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    unique case (state)
      POR_HOLD, REL_HOLD: begin
        if (btn_next[0]) begin
          state_next = BTN_HELD;
          hold_next  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
          hold_next  = '0;
        end else begin
          hold_next  = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        hold_next = '0;
        if (btn_next[0]) state_next = BTN_HELD;
      end
      BTN_HELD: begin
        hold_next = '0;
        if (!btn_next[0]) state_next = REL_HOLD;
      end
      default: begin
        state_next = POR_HOLD;
        hold_next  = '0;
      end
    endcase
    // Only a fresh press while running counts. A reset press on the same edge takes priority.
    nmi_next = btn_next[1] & ~BTN_STATE[1] & (state == RUN) & ~btn_next[0];
  end

  // FSM state, hold counter and the registered outputs.
  always_ff @(posedge CLK_32MHZ) begin
    if (RST) begin
      state     <= POR_HOLD;
      hold_cnt  <= '0;
      SYS_RESET <= 1'b1;
      NMI_PULSE <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      SYS_RESET <= (state_next != RUN);
      NMI_PULSE <= nmi_next;
    end
  end

endmodule
